pld_bus_master: RTL and testbench

PLD_BUS_MASTER -- requirements
Module: pld_bus_master

---
 rtl/pld_bus_master.sv | 193 +++++++++++++++++++
 tb/tb_pld_bus_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pld_bus_master.sv
// pld_bus_master
//   Asynchronous-style parallel bus master for a PLD register file. A request
//   accepted in IDLE runs SETUP -> STROBE -> (WAITST) -> HOLD -> IDLE with
//   nCE low for the whole transaction and nOE/nWE low during STROBE/WAITST.
//   The responder may stretch the strobe with nWAIT (synchronised here). A
//   stretch that exceeds WAIT_TIMEOUT cycles ends the strobe anyway, and the
//   completion is flagged with timeout.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   req, wr            request strobe, direction (1 = write); sampled in IDLE
//   addr, wdata        address / write data, latched with req
//   busy, ack          transaction in progress, one-cycle completion pulse
//   timeout            qualifies ack: the wait extension timed out
//   rdata              read data, held until the next read completes
//   nCE, nOE, nWE      active-low bus controls
//   bus_addr, data_out bus address and write data
//   data_oe            tristate enable for data_out
//   data_in            bus read data
//   nWAIT              responder wait, active low
module pld_bus_master #(
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned STROBE_CYC   = 4,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       ack,
  output logic       timeout,
  output logic [7:0] rdata,
  output logic       nCE,
  output logic       nOE,
  output logic       nWE,
  output logic [7:0] bus_addr,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in,
  input  logic       nWAIT
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAITST, HOLD} state_t;

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] WAIT_LAST   = 8'(WAIT_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_wcnt;
  logic       r_tflag;
  logic       r_wr;
  logic       r_wait_s1;
  logic       r_wait_s2;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_wcnt_nxt;
  logic       w_tflag_nxt;
  logic       w_ack_nxt;
  logic       w_cap;
  logic       w_accept;
  logic       w_wr_nxt;
  logic       w_strobe_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wcnt_nxt  = r_wcnt;
    w_tflag_nxt = r_tflag;
    w_ack_nxt   = 1'b0;
    w_cap       = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_state_nxt = SETUP;
          w_cnt_nxt   = '0;
          w_tflag_nxt = 1'b0;
        end
      end
      SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_nxt = STROBE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      STROBE: begin
        if (r_cnt == STROBE_LAST) begin
          w_cnt_nxt = '0;
          if (r_wait_s2) begin
            w_state_nxt = HOLD;
            w_cap       = 1'b1;
          end else begin
            w_state_nxt = WAITST;
            w_wcnt_nxt  = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      WAITST: begin
        // r_wcnt holds (completed wait cycles - 1); released wait wins over
        // a timeout landing on the same cycle.
        if (r_wait_s2) begin
          w_state_nxt = HOLD;
          w_cap       = 1'b1;
          w_cnt_nxt   = '0;
        end else if (r_wcnt == WAIT_LAST) begin
          w_state_nxt = HOLD;
          w_cap       = 1'b1;
          w_cnt_nxt   = '0;
          w_tflag_nxt = 1'b1;
        end else begin
          w_wcnt_nxt = r_wcnt + 8'd1;
        end
      end
      HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = IDLE;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_wr_nxt     = w_accept ? wr : r_wr;
    w_strobe_nxt = (w_state_nxt == STROBE) || (w_state_nxt == WAITST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_wcnt    <= '0;
      r_tflag   <= 1'b0;
      r_wait_s1 <= 1'b1;
      r_wait_s2 <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_tflag   <= w_tflag_nxt;
      r_wait_s1 <= nWAIT;
      r_wait_s2 <= r_wait_s1;
    end
  end

  // Outputs are registered from the next-state decode so they change on the
  // same edge as the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      ack      <= 1'b0;
      timeout  <= 1'b0;
      rdata    <= '0;
      nCE      <= 1'b1;
      nOE      <= 1'b1;
      nWE      <= 1'b1;
      bus_addr <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      busy    <= (w_state_nxt != IDLE);
      ack     <= w_ack_nxt;
      timeout <= w_ack_nxt & r_tflag;
      nCE     <= (w_state_nxt == IDLE);
      nOE     <= ~(w_strobe_nxt & ~w_wr_nxt);
      nWE     <= ~(w_strobe_nxt & w_wr_nxt);
      data_oe <= (w_state_nxt != IDLE) & w_wr_nxt;
      if (w_accept) begin
        bus_addr <= addr;
        data_out <= wdata;
        r_wr     <= wr;
      end
      if (w_cap && !r_wr) begin
        rdata <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_pld_bus_master.sv
module tb_pld_bus_master;

  localparam int S  = 2;
  localparam int T  = 4;
  localparam int H  = 2;
  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       ack;
  logic       timeout;
  logic [7:0] rdata;
  logic       nCE;
  logic       nOE;
  logic       nWE;
  logic [7:0] bus_addr;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;
  logic       nWAIT;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rdata;

  pld_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .ack(ack), .timeout(timeout), .rdata(rdata),
    .nCE(nCE), .nOE(nOE), .nWE(nWE), .bus_addr(bus_addr), .data_out(data_out),
    .data_oe(data_oe), .data_in(data_in), .nWAIT(nWAIT)
  );

  always #5 clk = ~clk;

  // nWAIT level in the cycle ending at edge j (edge 0 = request accept).
  function automatic bit wval(int j, int ws, int wl);
    return !(j >= ws && j < ws + wl);
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge of the ack cycle.
  task automatic do_txn(input bit t_wr, input logic [7:0] t_addr, input logic [7:0] t_wdata,
                        input logic [7:0] t_din, input int ws, input int wl, input bit hold,
                        input bit n_wr, input logic [7:0] n_addr, input logic [7:0] n_wdata);
    int x, a, m, k;
    bit to;
    logic [7:0] old_rd, new_rd;
    logic [6:0] exp_v, got_v;
    bit strobe, intx;
    // Reference: strobe ends at edge S+T unless the wait seen two cycles
    // late is low; then one wait cycle per edge until released or TO cycles.
    x = S + T;
    to = 1'b0;
    if (!wval(S + T - 2, ws, wl)) begin
      m = 1;
      while (1) begin
        k = S + T + m;
        if (wval(k - 2, ws, wl)) begin x = k; break; end
        if (m == TO) begin x = k; to = 1'b1; break; end
        m++;
      end
    end
    a = x + H;
    old_rd = exp_rdata;
    new_rd = t_wr ? old_rd : t_din;

    wr = t_wr; addr = t_addr; wdata = t_wdata; data_in = t_din; nWAIT = 1'b1; req = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= a; j++) begin
      @(negedge clk);
      intx   = (j < a);
      strobe = (j >= S) && (j < x);
      exp_v  = {intx, !intx, !(strobe && !t_wr), !(strobe && t_wr), intx && t_wr,
                j == a, (j == a) && to};
      got_v  = {busy, nCE, nOE, nWE, data_oe, ack, timeout};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL ctrl addr=%h cyc=%0d busy,nCE,nOE,nWE,oe,ack,to got %b exp %b",
                 t_addr, j, got_v, exp_v);
      end
      checks++;
      if (bus_addr !== t_addr) begin
        errors++;
        $display("FAIL bus_addr cyc=%0d got %h exp %h", j, bus_addr, t_addr);
      end
      if (t_wr) begin
        checks++;
        if (data_out !== t_wdata) begin
          errors++;
          $display("FAIL data_out cyc=%0d got %h exp %h", j, data_out, t_wdata);
        end
      end
      checks++;
      if (rdata !== ((j < x) ? old_rd : new_rd)) begin
        errors++;
        $display("FAIL rdata cyc=%0d got %h exp %h", j, rdata, (j < x) ? old_rd : new_rd);
      end
      nWAIT = wval(j + 1, ws, wl);
      if (j == 0) begin
        req = hold;
        if (hold) begin wr = n_wr; addr = n_addr; wdata = n_wdata; end
      end
    end
    exp_rdata = new_rd;
    nWAIT = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (nCE !== 1'b1 || ack !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle nCE,ack,busy got %b%b%b exp 100", nCE, ack, busy);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; data_in = '0; nWAIT = 1'b1;
    exp_rdata = '0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({busy, ack, timeout, nCE, nOE, nWE, data_oe} !== 7'b0001110 ||
        rdata !== 8'h00 || bus_addr !== 8'h00 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset ctrl got %b rdata %h addr %h dout %h exp 0001110 00 00 00",
               {busy, ack, timeout, nCE, nOE, nWE, data_oe}, rdata, bus_addr, data_out);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_write;
    do_txn(1'b1, 8'h01, 8'hA5, 8'hEE, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle_cycles(2);
  endtask

  task automatic test_read;
    do_txn(1'b0, 8'h0F, 8'h00, 8'h5A, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle_cycles(2);
  endtask

  task automatic test_read_wait;
    do_txn(1'b0, 8'h10, 8'h00, 8'hC7, 3, 10, 1'b0, 1'b0, 8'h00, 8'h00);
    idle_cycles(2);
  endtask

  task automatic test_timeout;
    do_txn(1'b0, 8'h20, 8'h00, 8'h33, 2, 1000, 1'b0, 1'b0, 8'h00, 8'h00);
    idle_cycles(3);
  endtask

  task automatic test_reset_abort;
    wr = 1'b1; addr = 8'h77; wdata = 8'h99; req = 1'b1;
    @(posedge clk);
    @(negedge clk) req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (nWE !== 1'b0 || nCE !== 1'b0 || data_oe !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre nCE,nWE,oe got %b%b%b exp 001", nCE, nWE, data_oe);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({nCE, nWE, nOE, data_oe, busy, ack} !== 6'b111000 || bus_addr !== 8'h00 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL abort_async got %b addr %h rdata %h exp 111000 00 00",
               {nCE, nWE, nOE, data_oe, busy, ack}, bus_addr, rdata);
    end
    exp_rdata = '0;
    @(negedge clk) rst = 1'b1;
    idle_cycles(12);
    do_txn(1'b1, 8'h05, 8'h3C, 8'h11, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back;
    do_txn(1'b1, 8'h21, 8'h42, 8'h00, 0, 0, 1'b1, 1'b0, 8'h84, 8'h00);
    do_txn(1'b0, 8'h84, 8'h00, 8'h6B, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle_cycles(2);
  endtask

  task automatic test_random;
    bit          r_w;
    logic [7:0]  r_a, r_d, r_i;
    int          ws, wl;
    for (int i = 0; i < 10; i++) begin
      r_w = 1'($urandom % 2);
      r_a = 8'($urandom);
      r_d = 8'($urandom);
      r_i = 8'($urandom);
      ws  = int'($urandom_range(0, 10));
      wl  = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 20));
      do_txn(r_w, r_a, r_d, r_i, ws, wl, 1'b0, 1'b0, 8'h00, 8'h00);
      idle_cycles(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_read_wait;
    test_timeout;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
